// File: rtl/gc_table_streamer.sv
// Garbled-gate output stage: label writes to wire-label memory, tables buffered and streamed as framed packets.
// Optional GC_FREE_XOR_SKIP_EN: XOR/XNOR gates write their label but push no table.
module gc_table_streamer #(
  parameter int S         = 20,
  parameter int K         = 128,
  parameter int W         = 32,
  parameter int DEPTH     = 8,
  parameter int AF_MARGIN = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [S-1:0] in_gid,
  input  logic [3:0]   in_g_logic,
  input  logic [K-1:0] in_t0,
  input  logic [K-1:0] in_t1,
  input  logic [K-1:0] in_out_label,
  output logic         lbl_we,
  output logic [S-1:0] lbl_addr,
  output logic [K-1:0] lbl_data,
  output logic         almost_full,
  output logic         overflow,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic [W-1:0] tx_data,
  output logic         tx_first,
  output logic         tx_last
);

  localparam int NB   = K / W;
  localparam int CW   = (NB > 1) ? $clog2(NB) : 1;
  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;
  localparam logic [CW-1:0]   LAST_BEAT = CW'(NB - 1);
  localparam logic [CNTW-1:0] FULL_CNT  = CNTW'(DEPTH);
  localparam logic [CNTW-1:0] AF_CNT    = CNTW'(DEPTH - AF_MARGIN);

  typedef enum logic [1:0] {IDLE, HDR, T0, T1} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   beat_reg, beat_next;
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CNTW-1:0] count_reg, count_next;
  logic            overflow_reg;
  logic            lbl_we_reg;
  logic [S-1:0]    lbl_addr_reg;
  logic [K-1:0]    lbl_data_reg;

  logic [S-1:0]    gid_mem [DEPTH];
  logic [K-1:0]    t0_mem  [DEPTH];
  logic [K-1:0]    t1_mem  [DEPTH];

  logic            push_req, push_ok, pop, tx_fire, full, empty;
  logic [S-1:0]    head_gid;
  logic [K-1:0]    head_t0, head_t1;
  logic [W-1:0]    t0_slice [NB];
  logic [W-1:0]    t1_slice [NB];

`ifdef GC_FREE_XOR_SKIP_EN
  assign push_req = in_valid && !(in_g_logic == 4'b0110 || in_g_logic == 4'b1001);
`else
  logic unused_g_logic;
  assign unused_g_logic = ^in_g_logic;
  assign push_req = in_valid;
`endif

  assign full       = (count_reg == FULL_CNT);
  assign empty      = (count_reg == '0);
  assign tx_fire    = tx_valid && tx_ready;
  assign pop        = (state_reg == T1) && (beat_reg == LAST_BEAT) && tx_fire;
  // A pop on the same edge frees the slot the push needs.
  assign push_ok    = push_req && (!full || pop);
  assign count_next = count_reg + CNTW'(push_ok) - CNTW'(pop);

  // Label path is unconditional, independent of FIFO state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lbl_we_reg   <= 1'b0;
      lbl_addr_reg <= '0;
      lbl_data_reg <= '0;
    end else begin
      lbl_we_reg <= in_valid;
      if (in_valid) begin
        lbl_addr_reg <= in_gid;
        lbl_data_reg <= in_out_label;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      state_reg    <= IDLE;
      beat_reg     <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + AW'(1);
      if (push_req && !push_ok) overflow_reg <= 1'b1;
      count_reg <= count_next;
      state_reg <= state_next;
      beat_reg  <= beat_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      gid_mem[wr_ptr_reg] <= in_gid;
      t0_mem[wr_ptr_reg]  <= in_t0;
      t1_mem[wr_ptr_reg]  <= in_t1;
    end
  end

  assign head_gid = gid_mem[rd_ptr_reg];
  assign head_t0  = t0_mem[rd_ptr_reg];
  assign head_t1  = t1_mem[rd_ptr_reg];

  for (genvar gi = 0; gi < NB; gi++) begin : g_slice
    assign t0_slice[gi] = head_t0[gi*W +: W];
    assign t1_slice[gi] = head_t1[gi*W +: W];
  end

  always_comb begin
    state_next = state_reg;
    beat_next  = beat_reg;
    unique case (state_reg)
      IDLE: begin
        beat_next = '0;
        if (!empty) state_next = HDR;
      end
      HDR: if (tx_fire) begin
        state_next = T0;
        beat_next  = '0;
      end
      T0: if (tx_fire) begin
        if (beat_reg == LAST_BEAT) begin
          state_next = T1;
          beat_next  = '0;
        end else begin
          beat_next = beat_reg + CW'(1);
        end
      end
      T1: if (tx_fire) begin
        if (beat_reg == LAST_BEAT) begin
          beat_next  = '0;
          state_next = (count_next != '0) ? HDR : IDLE;
        end else begin
          beat_next = beat_reg + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Beat payload is a pure function of state and head entry, so it holds while stalled.
  always_comb begin
    tx_data = '0;
    unique case (state_reg)
      HDR:     tx_data[S-1:0] = head_gid;
      T0:      tx_data = t0_slice[beat_reg];
      T1:      tx_data = t1_slice[beat_reg];
      default: tx_data = '0;
    endcase
  end

  assign tx_valid    = (state_reg != IDLE);
  assign tx_first    = (state_reg == HDR);
  assign tx_last     = (state_reg == T1) && (beat_reg == LAST_BEAT);
  assign almost_full = (count_reg >= AF_CNT);
  assign overflow    = overflow_reg;
  assign lbl_we      = lbl_we_reg;
  assign lbl_addr    = lbl_addr_reg;
  assign lbl_data    = lbl_data_reg;

endmodule

// File: tb/tb_gc_table_streamer.sv
// Directed bench for gc_table_streamer: scoreboarded beats/labels plus timing, overflow and reset checks.
module tb_gc_table_streamer;
  localparam int S = 20, K = 128, W = 32, DEPTH = 8, AF_MARGIN = 4;
`ifdef GC_FREE_XOR_SKIP_EN
  localparam int XOR_PKTS = 2;
  localparam bit SKIP_XOR = 1'b1;
`else
  localparam int XOR_PKTS = 4;
  localparam bit SKIP_XOR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [S-1:0] in_gid;
  logic [3:0]   in_g_logic;
  logic [K-1:0] in_t0, in_t1, in_out_label;
  logic         lbl_we;
  logic [S-1:0] lbl_addr;
  logic [K-1:0] lbl_data;
  logic         almost_full, overflow;
  logic         tx_valid, tx_ready, tx_first, tx_last;
  logic [W-1:0] tx_data;

  gc_table_streamer #(.S(S), .K(K), .W(W), .DEPTH(DEPTH), .AF_MARGIN(AF_MARGIN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_gid(in_gid), .in_g_logic(in_g_logic),
    .in_t0(in_t0), .in_t1(in_t1), .in_out_label(in_out_label),
    .lbl_we(lbl_we), .lbl_addr(lbl_addr), .lbl_data(lbl_data),
    .almost_full(almost_full), .overflow(overflow),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_first(tx_first), .tx_last(tx_last)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int pkt_cnt  = 0;
  logic [W+1:0]   exp_q[$];
  logic [S+K-1:0] lbl_q[$];
  logic [3:0]     xor_lgs [4] = '{4'b1000, 4'b0110, 4'b1001, 4'b1000};

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mk_row(input logic [11:0] tag, input logic [19:0] gid);
    return {tag | 12'h003, gid, tag | 12'h002, gid, tag | 12'h001, gid, tag, gid};
  endfunction

  function automatic logic [127:0] lbl_of(input logic [19:0] gid);
    return {8'hC3, 100'd0, gid};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_packet(input logic [19:0] gid, input logic [127:0] t0, input logic [127:0] t1);
    exp_q.push_back({1'b1, 1'b0, 12'h000, gid});
    for (int j = 0; j < 4; j++) exp_q.push_back({2'b00, t0[j*32 +: 32]});
    for (int j = 0; j < 4; j++) exp_q.push_back({1'b0, (j == 3), t1[j*32 +: 32]});
  endtask

  task automatic put_gate(input logic [19:0] gid, input logic [3:0] lg, input logic [127:0] t0,
                          input logic [127:0] t1, input bit exp_pkt);
    in_valid     = 1'b1;
    in_gid       = gid;
    in_g_logic   = lg;
    in_t0        = t0;
    in_t1        = t1;
    in_out_label = lbl_of(gid);
    lbl_q.push_back({gid, lbl_of(gid)});
    if (exp_pkt) expect_packet(gid, t0, t1);
  endtask

  task automatic std_gate(input logic [19:0] gid, input logic [3:0] lg, input bit exp_pkt);
    put_gate(gid, lg, mk_row(12'hA00, gid), mk_row(12'hB00, gid), exp_pkt);
  endtask

  task automatic drain(input bit toggle);
    for (int c = 0; c < 400 && exp_q.size() != 0; c++) begin
      if (toggle) tx_ready = ~tx_ready;
      else        tx_ready = 1'b1;
      tick();
    end
    tx_ready = 1'b1;
    repeat (3) tick();
    check("drain_beats_left", exp_q.size(), 0);
    check("drain_labels_left", lbl_q.size(), 0);
  endtask

  // Handshakes are predicted at the falling edge, inputs being stable until after the next rise.
  logic           stall_prev = 1'b0;
  logic [W+1:0]   held, eb;
  logic [S+K-1:0] el;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid_hold", tx_valid, 1'b1);
        check("stall_beat_hold", {tx_first, tx_last, tx_data}, held);
      end
      if (tx_valid && tx_ready) begin
        check("beat_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          eb = exp_q.pop_front();
          check("beat", {tx_first, tx_last, tx_data}, eb);
        end
        if (tx_last) pkt_cnt++;
      end
      stall_prev = tx_valid && !tx_ready;
      held = {tx_first, tx_last, tx_data};
      if (lbl_we) begin
        check("label_expected", lbl_q.size() != 0, 1'b1);
        if (lbl_q.size() != 0) begin
          el = lbl_q.pop_front();
          check("lbl_addr", lbl_addr, el[S+K-1:K]);
          check("lbl_data", lbl_data, el[K-1:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic saw_valid;
  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_gid = '0; in_g_logic = '0;
    in_t0 = '0; in_t1 = '0; in_out_label = '0; tx_ready = 1'b0;
    repeat (2) tick();
    check("rst_lbl_we", lbl_we, 1'b0);
    check("rst_lbl_addr", lbl_addr, 0);
    check("rst_lbl_data", lbl_data, 0);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data", tx_data, 0);
    check("rst_tx_first_last", {tx_first, tx_last}, 2'b00);
    check("rst_overflow", overflow, 1'b0);
    check("rst_almost_full", almost_full, 1'b0);
    rst_n = 1'b1;
    tick();

    // Single AND gate with hand-computed beats
    tx_ready = 1'b1; pkt_cnt = 0;
    put_gate(20'd5, 4'b1000, 128'h1, 128'h2, 1'b0);
    exp_q.push_back({2'b10, 32'h5});
    exp_q.push_back({2'b00, 32'h1});
    repeat (3) exp_q.push_back({2'b00, 32'h0});
    exp_q.push_back({2'b00, 32'h2});
    repeat (2) exp_q.push_back({2'b00, 32'h0});
    exp_q.push_back({2'b01, 32'h0});
    tick();
    in_valid = 1'b0;
    check("and_lbl_we", lbl_we, 1'b1);
    check("and_lbl_addr", lbl_addr, 5);
    check("and_no_tx_yet", tx_valid, 1'b0);
    tick();
    check("and_hdr_valid", tx_valid, 1'b1);
    check("and_hdr_first", tx_first, 1'b1);
    check("and_hdr_data", tx_data, 32'h5);
    repeat (12) tick();
    check("and_beats_left", exp_q.size(), 0);
    check("and_pkt_cnt", pkt_cnt, 1);

    // Backpressure: three back-to-back gates, tx_ready toggling
    pkt_cnt = 0; tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      std_gate(20'(100 + i), 4'b1000, 1'b1);
      tx_ready = ~tx_ready;
      tick();
    end
    in_valid = 1'b0;
    drain(1'b1);
    check("bp_pkt_cnt", pkt_cnt, 3);

    // Free-XOR gates
    pkt_cnt = 0; tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      std_gate(20'(i), xor_lgs[i],
               !(SKIP_XOR && (xor_lgs[i] == 4'b0110 || xor_lgs[i] == 4'b1001)));
      tick();
    end
    in_valid = 1'b0;
    drain(1'b0);
    check("xor_pkt_cnt", pkt_cnt, XOR_PKTS);
    check("xor_no_overflow", overflow, 1'b0);

    // Overflow: ten gates into a stalled stream
    pkt_cnt = 0; tx_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      std_gate(20'(i), 4'b1000, i < 8);
      tick();
      if (i == 2) check("ovf_af_at3", almost_full, 1'b0);
      if (i == 3) check("ovf_af_at4", almost_full, 1'b1);
      if (i == 7) check("ovf_clear_at8", overflow, 1'b0);
      if (i == 8) check("ovf_set_at9", overflow, 1'b1);
    end
    in_valid = 1'b0;
    drain(1'b0);
    check("ovf_pkt_cnt", pkt_cnt, 8);
    check("ovf_sticky", overflow, 1'b1);
    check("ovf_af_drained", almost_full, 1'b0);

    // Reset in the middle of beat 4 with two entries queued behind
    pkt_cnt = 0; tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      std_gate(20'(10 + i), 4'b1000, 1'b1);
      tick();
    end
    in_valid = 1'b0;
    tx_ready = 1'b1;
    repeat (4) tick();
    check("mid_beat4_data", tx_data, {12'hA03, 20'd10});
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    lbl_q.delete();
    #1;
    check("mid_rst_tx_valid", tx_valid, 1'b0);
    check("mid_rst_tx_data", tx_data, 0);
    check("mid_rst_first_last", {tx_first, tx_last}, 2'b00);
    check("mid_rst_overflow", overflow, 1'b0);
    check("mid_rst_lbl_we", lbl_we, 1'b0);
    tick();
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (tx_valid) saw_valid = 1'b1;
    end
    check("mid_no_tx_after_rst", saw_valid, 1'b0);

    // Full FIFO: push in the same cycle as the head's last-beat handshake
    pkt_cnt = 0; tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      std_gate(20'(20 + i), 4'b1000, 1'b1);
      tick();
    end
    in_valid = 1'b0;
    check("fb_af_full", almost_full, 1'b1);
    tx_ready = 1'b1;
    repeat (8) tick();
    check("fb_last_presented", tx_last, 1'b1);
    std_gate(20'd28, 4'b1000, 1'b1);
    tick();
    in_valid = 1'b0;
    check("fb_no_overflow", overflow, 1'b0);
    check("fb_next_hdr", {tx_valid, tx_first, tx_data}, {2'b11, 32'd21});
    drain(1'b0);
    check("fb_pkt_cnt", pkt_cnt, 9);
    check("fb_overflow_final", overflow, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/gc_table_streamer.md
# gc_table_streamer

Output stage for the half-gate garbling pipeline. Captures one garbled gate per cycle from a fixed-latency, non-stallable garbling engine (gid, g_logic, t0, t1, out_label). Writes every output label straight to the wire-label memory. Buffers the garbled tables in a FIFO and streams each table as a framed packet on a narrow valid/ready bus toward the host/evaluator link.

## Interface
Parameters:
- S, 20, gate-id width; must satisfy S <= W.
- K, 128, label/table-row width; must be a multiple of W.
- W, 32, output stream width.
- DEPTH, 8, table FIFO entries; power of two, >= 2.
- AF_MARGIN, 4, almost_full asserts when occupancy >= DEPTH - AF_MARGIN; 1 <= AF_MARGIN < DEPTH.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  engine output valid; no backpressure is possible.
- in_gid  in  S  gate id.
- in_g_logic  in  4  gate truth table.
- in_t0, in_t1  in  K  garbled table rows.
- in_out_label  in  K  garbled output label (zero semantics).
- lbl_we  out  1  label-memory write strobe.
- lbl_addr  out  S  label-memory address (= gid).
- lbl_data  out  K  label-memory write data.
- almost_full  out  1  tells the gate issuer to stop issuing.
- overflow  out  1  sticky, set when a table is dropped.
- tx_valid  out  1  stream beat valid.
- tx_ready  in  1  stream beat accepted when high with tx_valid.
- tx_data  out  W  beat payload.
- tx_first, tx_last  out  1  first and last beat of a packet.

## Operation
- **Label path:** every in_valid cycle registers lbl_we=1, lbl_addr=in_gid and lbl_data=in_out_label one cycle later. This applies unconditionally, including on FIFO full.
- **Table push:** when in_valid is high and the entry is table-bearing (see Configuration), push {gid, t0, t1}.
  - Push while full with no pop in the same cycle: the entry is dropped and overflow is set to 1 until reset.
  - Push while full with a pop in the same cycle: the push is accepted and occupancy is unchanged.
- **Packet format:** 1 + 2K/W beats; 9 beats at the default parameters.
  - Beat 0 is the header: gid zero-extended to W, with tx_first=1.
  - Beats 1..K/W carry t0, least-significant W-bit slice first.
  - The next K/W beats carry t1, same order. The final beat has tx_last=1.
- **FSM:** IDLE, HDR, T0, T1.
  - IDLE→HDR when the FIFO is not empty.
  - HDR→T0 on handshake.
  - T0→T1 on the handshake of beat K/W-1 of the T0 slice counter.
  - T1→HDR on the last-beat handshake if the FIFO still holds a further entry after the pop; otherwise T1→IDLE.
- **Pop:** the FIFO pops on the last-beat handshake.
- **Stall rules:** no beat advances without a handshake. tx_data, tx_first and tx_last hold stable while tx_valid=1 and tx_ready=0.
- **Occupancy:** counts the packet currently being streamed, so the head entry stays in the FIFO until its last beat is accepted.
- **almost_full:** combinational from occupancy.

## Timing
- Reset values: lbl_we=0, lbl_addr=0, lbl_data=0, tx_valid=0, tx_data=0, tx_first=0, tx_last=0, overflow=0, almost_full=0, FSM=IDLE, FIFO empty.
- Reset asserted mid-packet aborts the packet immediately and discards the FIFO. No partial packet resumes after reset.
- Label write latency: 1 cycle from in_valid.
- Table latency, empty FIFO: in_valid at edge n gives tx_valid=1 with the header during cycle n+1.
- Back-to-back packets: with tx_ready held high, a packet occupies exactly 1 + 2K/W cycles. The next header follows the previous last beat with no bubble.
- Sustained throughput is one table per 1 + 2K/W cycles. The issuer must honour almost_full to avoid overflow.

## Configuration
- GC_FREE_XOR_SKIP_EN
  - Defined: gates with in_g_logic of 4'b0110 (XOR) or 4'b1001 (XNOR) are free-XOR gates. They are not pushed and emit no packet; their label write still occurs. They never set overflow.
  - Undefined: every in_valid pushes a table, with XOR tables streamed as delivered (zero rows from the engine).

## Test plan
- Single AND gate (K=128, W=32): in_gid=5, g_logic=4'b1000, t0=128'h0…01, t1=128'h0…02, tx_ready=1.
  - Label write gid 5 occurs one cycle later.
  - 9 beats follow, starting the cycle after the write strobe: 32'h5, then 32'h1, 0, 0, 0, then 32'h2, 0, 0, 0.
  - tx_first is high on beat 0 only; tx_last is high on beat 8 only.
- Backpressure: 3 gates back-to-back, tx_ready toggling 1/0 every cycle.
  - All 27 beats arrive in order.
  - tx_data is stable across every stall.
  - No beat is duplicated or lost.
- Overflow: DEPTH=8, tx_ready=0, 10 consecutive in_valid.
  - almost_full rises when occupancy reaches 4.
  - The 9th and 10th gates are dropped and overflow=1.
  - All 10 label writes occur.
  - Releasing tx_ready yields exactly 8 packets, gids 0–7.
- Free-XOR skip (macro defined): gates AND, XOR, XNOR, AND with gids 0–3 give packets for gid 0 and 3 only, plus 4 label writes. With the macro undefined, 4 packets.
- Reset mid-packet: assert rst_n=0 during beat 4 with 2 entries queued.
  - All outputs are immediately at their reset values.
  - After release, no tx_valid appears until a new in_valid.
- Full-boundary push/pop: with the FIFO full, push a new gate in the same cycle as a last-beat handshake. The push is accepted and overflow stays 0.
